// File: rtl/fetch_pc_if.sv
// fetch_pc_if: fetch unit control inputs and instruction-memory/decode outputs
interface fetch_pc_if;
  logic        stall;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] pc;
  logic        imem_stall;
  logic        imem_jump;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        misalign;
  modport master (
    input  stall, jump, jump_target,
    output pc, imem_stall, imem_jump, inst_pc, inst_valid, misalign
  );
  modport slave (
    output stall, jump, jump_target,
    input  pc, imem_stall, imem_jump, inst_pc, inst_valid, misalign
  );
endinterface

// File: rtl/fetch_pc.sv
// fetch_pc: program counter for block-RAM fetch with redirect squash and stall-time redirect buffering
module fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic      clk,
  input logic      rst_n,
  fetch_pc_if.master bus
);
  typedef enum logic [1:0] {RUN, HOLD, PEND} state_t;
  state_t      state;
  logic [31:0] pc, inst_pc, pend_target, eff_target;
  logic        inst_valid, misalign, eff_jump;
  assign eff_jump       = bus.jump | (state == PEND);
  assign eff_target     = bus.jump ? bus.jump_target : pend_target;
  assign bus.imem_stall = bus.stall;
  assign bus.imem_jump  = ~bus.stall & eff_jump;
  assign bus.pc         = pc;
  assign bus.inst_pc    = inst_pc;
  assign bus.inst_valid = inst_valid;
  assign bus.misalign   = misalign;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      inst_pc     <= '0;
      inst_valid  <= 1'b0;
      misalign    <= 1'b0;
      pend_target <= '0;
    end else if (bus.stall) begin
      misalign <= 1'b0;
      state    <= eff_jump ? PEND : HOLD;
      if (eff_jump) pend_target <= eff_target;
    end else if (eff_jump) begin
      pc          <= {eff_target[31:2], 2'b00};
      inst_pc     <= '0;
      inst_valid  <= 1'b0;
      misalign    <= |eff_target[1:0];
      state       <= RUN;
      pend_target <= '0;
    end else begin
      inst_pc     <= pc;
      inst_valid  <= 1'b1;
      pc          <= pc + 32'd4;
      misalign    <= 1'b0;
      state       <= RUN;
      pend_target <= '0;
    end
endmodule
